// File: rtl/hazard_scoreboard.sv
// Hazard detection, operand forwarding and long-latency register scoreboard
// for the F/D/E/M/W core; stall and flush outputs are purely combinational.
module hazard_scoreboard #(
  parameter int NUM_REGS        = 32,
  parameter int REG_ADDR_W      = 5,
  parameter int NUM_READ_PORTS  = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NUM_READ_PORTS*REG_ADDR_W-1:0] rs_d_i,
  input  logic [REG_ADDR_W-1:0]                rd_d_i,
  input  logic                                 reg_write_d_i,
  input  logic                                 long_op_d_i,
  input  logic [NUM_READ_PORTS*REG_ADDR_W-1:0] rs_e_i,
  input  logic [REG_ADDR_W-1:0]                rd_e_i,
  input  logic [REG_ADDR_W-1:0]                rd_m_i,
  input  logic [REG_ADDR_W-1:0]                rd_w_i,
  input  logic                                 reg_write_e_i,
  input  logic                                 reg_write_m_i,
  input  logic                                 reg_write_w_i,
  input  logic [1:0]                           result_src_e_i,
  input  logic                                 long_issue_e_i,
  input  logic                                 pc_src_e_i,
  input  logic                                 dmem_stall_i,
  input  logic                                 long_wb_valid_i,
  input  logic [REG_ADDR_W-1:0]                long_wb_rd_i,
  output logic                                 stall_f_o,
  output logic                                 stall_d_o,
  output logic                                 stall_e_o,
  output logic                                 stall_m_o,
  output logic                                 flush_d_o,
  output logic                                 flush_e_o,
  output logic                                 flush_w_o,
  output logic [NUM_READ_PORTS*2-1:0]          forward_e_o,
  output logic [NUM_REGS-1:0]                  pending_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  logic [NUM_REGS-1:0] r_pending;
  logic [CW-1:0]       r_count;

  logic [NUM_REGS-1:0] w_wb_hot;
  logic [NUM_REGS-1:0] w_set_hot;
  logic [NUM_REGS-1:0] w_eff;
  logic [NUM_REGS-1:0] w_pend_nxt;
  logic [CW-1:0]       w_cnt_nxt;
  logic [CW:0]         w_cap_lhs;
  logic [CW:0]         w_cap_rhs;
  logic                w_inc;
  logic                w_dec;
  logic                w_set;
  logic                w_load_e;
  logic                w_cap;
  logic                w_hz;
  logic [NUM_READ_PORTS*2-1:0] w_fwd;

  assign w_inc    = long_issue_e_i && !dmem_stall_i;
  assign w_set    = w_inc && (rd_e_i != '0);
  // an x0 long op has no pending bit, but its writeback still retires it
  assign w_dec    = long_wb_valid_i &&
                    (r_pending[long_wb_rd_i] || (long_wb_rd_i == '0));
  assign w_load_e = result_src_e_i[0] && reg_write_e_i && (rd_e_i != '0);

  always_comb begin
    w_wb_hot  = '0;
    w_set_hot = '0;
    if (long_wb_valid_i) w_wb_hot[long_wb_rd_i] = 1'b1;
    if (w_set)           w_set_hot[rd_e_i]      = 1'b1;
  end

  assign w_eff      = r_pending & ~w_wb_hot;
  assign w_pend_nxt = (r_pending & ~w_wb_hot) | w_set_hot;

  assign w_cap_lhs = {1'b0, r_count} + (CW+1)'(long_issue_e_i);
  assign w_cap_rhs = (CW+1)'(MAX_OUTSTANDING) + (CW+1)'(w_dec);
  assign w_cap     = long_op_d_i && (w_cap_lhs >= w_cap_rhs);

  always_comb begin
    w_hz  = w_cap;
    w_fwd = '0;
    if (reg_write_d_i && (rd_d_i != '0) && w_eff[rd_d_i]) w_hz = 1'b1;
    for (int k = 0; k < NUM_READ_PORTS; k++) begin
      if (rs_d_i[k*REG_ADDR_W +: REG_ADDR_W] != '0) begin
        if (w_eff[rs_d_i[k*REG_ADDR_W +: REG_ADDR_W]]) w_hz = 1'b1;
        if (w_load_e &&
            rd_e_i == rs_d_i[k*REG_ADDR_W +: REG_ADDR_W]) w_hz = 1'b1;
      end
      if (rs_e_i[k*REG_ADDR_W +: REG_ADDR_W] != '0) begin
        if (reg_write_m_i &&
            rs_e_i[k*REG_ADDR_W +: REG_ADDR_W] == rd_m_i)
          w_fwd[k*2 +: 2] = 2'b10;
        else if (reg_write_w_i &&
                 rs_e_i[k*REG_ADDR_W +: REG_ADDR_W] == rd_w_i)
          w_fwd[k*2 +: 2] = 2'b01;
      end
    end
  end

  always_comb begin
    stall_f_o   = 1'b0;
    stall_d_o   = 1'b0;
    stall_e_o   = 1'b0;
    stall_m_o   = 1'b0;
    flush_d_o   = 1'b0;
    flush_e_o   = 1'b0;
    flush_w_o   = 1'b0;
    forward_e_o = '0;
    priority case (1'b1)
      rst_i: begin
        flush_d_o = 1'b1;
        flush_e_o = 1'b1;
      end
      dmem_stall_i: begin
        stall_f_o   = 1'b1;
        stall_d_o   = 1'b1;
        stall_e_o   = 1'b1;
        stall_m_o   = 1'b1;
        flush_w_o   = 1'b1;
        forward_e_o = w_fwd;
      end
      pc_src_e_i: begin
        flush_d_o   = 1'b1;
        flush_e_o   = 1'b1;
        forward_e_o = w_fwd;
      end
      w_hz: begin
        stall_f_o   = 1'b1;
        stall_d_o   = 1'b1;
        flush_e_o   = 1'b1;
        forward_e_o = w_fwd;
      end
      default: forward_e_o = w_fwd;
    endcase
  end

  always_comb begin
    w_cnt_nxt = r_count;
    if (w_inc && !w_dec) begin
      if (r_count != MAX_CNT) w_cnt_nxt = r_count + 1'b1;
    end else if (!w_inc && w_dec) begin
      if (r_count != '0) w_cnt_nxt = r_count - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pending <= '0;
      r_count   <= '0;
    end else begin
      r_pending <= w_pend_nxt;
      r_count   <= w_cnt_nxt;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!rst_i) begin
      if (long_wb_valid_i && !w_dec)
        $warning("hazard_scoreboard: writeback to idle x%0d", long_wb_rd_i);
      if (w_inc && !w_dec && r_count == MAX_CNT)
        $warning("hazard_scoreboard: outstanding count overflow");
      if (w_dec && !w_inc && r_count == '0)
        $warning("hazard_scoreboard: outstanding count underflow");
    end
  end
`endif

  assign pending_o     = r_pending;
  assign outstanding_o = r_count;

endmodule
